// File: rtl/bfp_stream_normalizer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bfp_stream_normalizer_pkg
//  Description : Shared definitions for the block-floating-point stream
//                normalizer: FSM state encoding, default field sizes and
//                helpers that derive field positions within an input word
//                (sign | exponent | mantissa).
//  Revision    : 1.0 - initial release
// ============================================================================
package bfp_stream_normalizer_pkg;

    // Two-phase controller: collect a block, then stream it back out aligned.
    typedef enum logic [0:0] {
        STATE_FILL  = 1'b0,
        STATE_DRAIN = 1'b1
    } state_e;

    // Default element format (half-precision style).
    localparam int DEF_EXP_SIZE  = 5;
    localparam int DEF_MANT_SIZE = 10;

    // Bit index of the sign within an element.
    function automatic int sign_pos(input int exp_size, input int mant_size);
        return exp_size + mant_size;
    endfunction

    // Lowest bit index of the exponent field within an element.
    function automatic int exp_lsb(input int mant_size);
        return mant_size;
    endfunction

    // Width of the magnitude once the hidden bit is restored.
    function automatic int mag_width(input int mant_size);
        return mant_size + 1;
    endfunction

endpackage : bfp_stream_normalizer_pkg
`default_nettype wire

// File: rtl/bfp_align_shift.sv
`default_nettype none
// ============================================================================
//  Module      : bfp_align_shift
//  Description : Combinational alignment of one element to the shared block
//                exponent. Restores the hidden bit (zero/subnormal exponents
//                flush it to 0), right-shifts by (block_exp - exp), and in
//                rounding mode adds the most significant shifted-out bit with
//                saturation. The sign is passed through untouched.
//  Ports       : elem      - input element {sign, exp, mant}
//                block_exp - shared block exponent (>= element exponent)
//                aligned   - {sign, aligned magnitude[MANT_SIZE:0]}
//  Revision    : 1.0 - initial release
// ============================================================================
module bfp_align_shift
    import bfp_stream_normalizer_pkg::*;
#(
    parameter int EXP_SIZE  = DEF_EXP_SIZE,
    parameter int MANT_SIZE = DEF_MANT_SIZE,
    parameter int ROUND_EN  = 0
) (
    input  logic [EXP_SIZE+MANT_SIZE:0] elem,
    input  logic [EXP_SIZE-1:0]         block_exp,
    output logic [MANT_SIZE+1:0]        aligned
);

    localparam int c_mag_w    = mag_width(MANT_SIZE);
    localparam int c_sign_pos = sign_pos(EXP_SIZE, MANT_SIZE);
    localparam int c_exp_lsb  = exp_lsb(MANT_SIZE);

    logic                 w_sign;
    logic [EXP_SIZE-1:0]  w_exp;
    logic [MANT_SIZE-1:0] w_mant;
    logic [c_mag_w-1:0]   w_mag;
    logic [EXP_SIZE-1:0]  w_shift;
    logic [c_mag_w-1:0]   w_mag_out;

    assign w_sign  = elem[c_sign_pos];
    assign w_exp   = elem[c_exp_lsb +: EXP_SIZE];
    assign w_mant  = elem[MANT_SIZE-1:0];
    assign w_mag   = {(|w_exp), w_mant};
    // The block exponent is the max over the block, so this never wraps.
    assign w_shift = block_exp - w_exp;

    generate
        if (ROUND_EN != 0) begin : g_round
            // Shift with one guard bit appended: the low bit of the result is
            // the most significant bit shifted out (0 for shift 0). Large
            // shifts push everything out, giving 0 with no rounding.
            logic [c_mag_w:0] w_ext;
            logic [c_mag_w:0] w_sum;

            assign w_ext     = {w_mag, 1'b0} >> w_shift;
            assign w_sum     = {1'b0, w_ext[c_mag_w:1]} + {{c_mag_w{1'b0}}, w_ext[0]};
            assign w_mag_out = w_sum[c_mag_w] ? {c_mag_w{1'b1}} : w_sum[c_mag_w-1:0];
        end else begin : g_trunc
            assign w_mag_out = w_mag >> w_shift;
        end
    endgenerate

    assign aligned = {w_sign, w_mag_out};

endmodule : bfp_align_shift
`default_nettype wire

// File: rtl/bfp_stream_normalizer.sv
`default_nettype none
// ============================================================================
//  Module      : bfp_stream_normalizer
//  Description : Collects BLOCK_LEN floating-point elements, finds their
//                maximum exponent, then streams the elements back in arrival
//                order with mantissas aligned to that shared exponent.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                in_valid/in_ready   - input element handshake
//                in_data             - {sign, exp, mant} element
//                out_valid/out_ready - output element handshake
//                out_data            - {sign, aligned magnitude}
//                out_exp             - shared block exponent
//                out_last            - final element of a block
//  Revision    : 1.0 - initial release
// ============================================================================
module bfp_stream_normalizer
    import bfp_stream_normalizer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int EXP_SIZE   = DEF_EXP_SIZE,
    parameter int MANT_SIZE  = DEF_MANT_SIZE,
    parameter int BLOCK_LEN  = 9,
    parameter int ROUND_EN   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MANT_SIZE+1:0]  out_data,
    output logic [EXP_SIZE-1:0]   out_exp,
    output logic                  out_last
);

    localparam int               c_cnt_w    = $clog2(BLOCK_LEN);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BLOCK_LEN - 1);
    localparam logic [0:0]       c_st_fill  = STATE_FILL;
    localparam logic [0:0]       c_st_drain = STATE_DRAIN;
    localparam int               c_exp_lsb  = exp_lsb(MANT_SIZE);

    logic [0:0]            r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [EXP_SIZE-1:0]   r_max;
    logic [EXP_SIZE-1:0]   r_exp;
    logic [DATA_WIDTH-1:0] r_buf [BLOCK_LEN];

    logic                  w_in_acc;
    logic                  w_out_acc;
    logic                  w_cnt_at_last;
    logic [EXP_SIZE-1:0]   w_in_exp;
    logic [EXP_SIZE-1:0]   w_max_next;
    logic [DATA_WIDTH-1:0] w_drain_elem;
    logic [MANT_SIZE+1:0]  w_aligned;

    assign in_ready      = (r_state == c_st_fill);
    assign out_valid     = (r_state == c_st_drain);
    assign w_in_acc      = in_valid & in_ready;
    assign w_out_acc     = out_valid & out_ready;
    assign w_cnt_at_last = (r_cnt == c_cnt_last);

    // Running maximum including the element being accepted this cycle, so
    // the final accept of a block contributes to the shared exponent.
    assign w_in_exp   = in_data[c_exp_lsb +: EXP_SIZE];
    assign w_max_next = (w_in_exp > r_max) ? w_in_exp : r_max;

    // Element storage carries no reset: contents are only read in DRAIN,
    // which can only be reached after a complete block has been written.
    always_ff @(posedge clk) begin
        if (w_in_acc) begin
            r_buf[r_cnt] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_fill;
            r_cnt   <= '0;
            r_max   <= '0;
            r_exp   <= '0;
        end else begin
            case (r_state)
                c_st_fill: begin
                    if (w_in_acc) begin
                        if (w_cnt_at_last) begin
                            r_state <= c_st_drain;
                            r_cnt   <= '0;
                            r_exp   <= w_max_next;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                        end
                        r_max <= w_max_next;
                    end
                end
                c_st_drain: begin
                    if (w_out_acc) begin
                        if (w_cnt_at_last) begin
                            r_state <= c_st_fill;
                            r_cnt   <= '0;
                            r_max   <= '0;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_fill;
                    r_cnt   <= '0;
                    r_max   <= '0;
                end
            endcase
        end
    end

    // Index is held while stalled, so the output payload is stable.
    assign w_drain_elem = r_buf[r_cnt];

    bfp_align_shift #(
        .EXP_SIZE  (EXP_SIZE),
        .MANT_SIZE (MANT_SIZE),
        .ROUND_EN  (ROUND_EN)
    ) u_align (
        .elem      (w_drain_elem),
        .block_exp (r_exp),
        .aligned   (w_aligned)
    );

    // Payload is forced to zero outside DRAIN so stale buffer contents
    // never appear on the output.
    assign out_data = out_valid ? w_aligned : '0;
    assign out_exp  = r_exp;
    assign out_last = out_valid & w_cnt_at_last;

endmodule : bfp_stream_normalizer
`default_nettype wire

// File: tb/tb_bfp_stream_normalizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_bfp_stream_normalizer
//  Description : Self-checking bench. Two instances (truncate and round)
//                share all inputs; every output element is compared against
//                an integer-arithmetic reference of the alignment rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bfp_stream_normalizer;

    localparam int BL = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_data;

    logic        in_ready,   out_valid,   out_last;
    logic [11:0] out_data;
    logic [4:0]  out_exp;
    logic        in_ready_r, out_valid_r, out_last_r;
    logic [11:0] out_data_r;
    logic [4:0]  out_exp_r;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] blk [BL];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bfp_stream_normalizer #(.ROUND_EN(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_exp(out_exp), .out_last(out_last)
    );

    bfp_stream_normalizer #(.ROUND_EN(1)) dut_r (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r),
        .out_exp(out_exp_r), .out_last(out_last_r)
    );

    // Reference: value = {hidden,mant}; aligned = value / 2^shift, optionally
    // rounded half-up on the first discarded bit, clamped to 11 bits.
    function automatic logic [11:0] ref_align(input logic [15:0] x, input int bexp, input bit rnd);
        int e, mag, sh, m;
        e   = int'(x[14:10]);
        mag = ((e != 0) ? 1024 : 0) + int'(x[9:0]);
        sh  = bexp - e;
        if (sh >= (rnd ? 12 : 11)) m = 0;
        else begin
            m = mag >> sh;
            if (rnd && sh > 0 && ((mag >> (sh - 1)) & 1) == 1) m = m + 1;
            if (m > 2047) m = 2047;
        end
        return {x[15], 11'(m)};
    endfunction

    function automatic int block_max();
        int mx = 0;
        for (int i = 0; i < BL; i++) if (int'(blk[i][14:10]) > mx) mx = int'(blk[i][14:10]);
        return mx;
    endfunction

    task automatic pulse_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic fill_block(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    in_data  = 16'($urandom);
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = blk[i];
            total++;
            if (in_ready !== 1'b1 || in_ready_r !== 1'b1 || out_valid !== 1'b0 || out_valid_r !== 1'b0) begin
                bad++;
                $display("FAIL fill_hs idx=%0d in_ready=%b/%b out_valid=%b/%b required in_ready=1 out_valid=0",
                         i, in_ready, in_ready_r, out_valid, out_valid_r);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        if (n == BL) begin
            total++;
            if (out_valid !== 1'b1 || out_valid_r !== 1'b1 || in_ready !== 1'b0 || in_ready_r !== 1'b0) begin
                bad++;
                $display("FAIL first_valid out_valid=%b/%b in_ready=%b/%b required out_valid=1 in_ready=0",
                         out_valid, out_valid_r, in_ready, in_ready_r);
            end
        end
    endtask

    task automatic drain_block(input int stall_idx, input int stall_len, input bit rand_ready);
        int idx, budget, stalled, bexp;
        logic [11:0] snap_d, want_t, want_r;
        logic [4:0]  snap_e;
        logic        snap_l;
        idx = 0; budget = 0; stalled = 0; bexp = block_max();
        snap_d = '0; snap_e = '0; snap_l = 1'b0;
        while (idx < BL && budget < 200) begin
            total++;
            if (out_valid !== 1'b1 || out_valid_r !== 1'b1 || in_ready !== 1'b0 || in_ready_r !== 1'b0) begin
                bad++;
                $display("FAIL drain_hs idx=%0d out_valid=%b/%b in_ready=%b/%b required out_valid=1 in_ready=0",
                         idx, out_valid, out_valid_r, in_ready, in_ready_r);
            end
            if (idx == stall_idx && stalled < stall_len) begin
                out_ready = 1'b0;
                if (stalled == 0) begin
                    snap_d = out_data; snap_e = out_exp; snap_l = out_last;
                end else begin
                    total++;
                    if (out_data !== snap_d || out_exp !== snap_e || out_last !== snap_l) begin
                        bad++;
                        $display("FAIL stall_hold idx=%0d data=%h exp=%0d last=%b required data=%h exp=%0d last=%b",
                                 idx, out_data, out_exp, out_last, snap_d, snap_e, snap_l);
                    end
                end
                stalled++;
            end else begin
                out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (out_ready) begin
                    want_t = ref_align(blk[idx], bexp, 1'b0);
                    want_r = ref_align(blk[idx], bexp, 1'b1);
                    total++;
                    if (out_data !== want_t) begin
                        bad++;
                        $display("FAIL data_trunc idx=%0d in=%h got=%h required=%h", idx, blk[idx], out_data, want_t);
                    end
                    total++;
                    if (out_data_r !== want_r) begin
                        bad++;
                        $display("FAIL data_round idx=%0d in=%h got=%h required=%h", idx, blk[idx], out_data_r, want_r);
                    end
                    total++;
                    if (out_exp !== 5'(bexp) || out_exp_r !== 5'(bexp)) begin
                        bad++;
                        $display("FAIL out_exp idx=%0d got=%0d/%0d required=%0d", idx, out_exp, out_exp_r, bexp);
                    end
                    total++;
                    if (out_last !== (idx == BL - 1) || out_last_r !== (idx == BL - 1)) begin
                        bad++;
                        $display("FAIL out_last idx=%0d got=%b/%b required=%b", idx, out_last, out_last_r, (idx == BL - 1));
                    end
                    idx++;
                end
            end
            @(posedge clk); #1;
            budget++;
        end
        out_ready = 1'b0;
        total++;
        if (idx != BL) begin
            bad++;
            $display("FAIL drain_timeout transfers=%0d required=%0d", idx, BL);
        end
        total++;
        if (in_ready !== 1'b1 || in_ready_r !== 1'b1 || out_valid !== 1'b0 || out_valid_r !== 1'b0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL drain_done in_ready=%b/%b out_valid=%b/%b last=%b required in_ready=1 out_valid=0 last=0",
                     in_ready, in_ready_r, out_valid, out_valid_r, out_last);
        end
    endtask

    task automatic gen_random_block();
        int base, off, e;
        base = $urandom_range(1, 30);
        for (int i = 0; i < BL; i++) begin
            off = $urandom_range(0, 13);
            e   = (off > base) ? 0 : base - off;
            blk[i] = {1'($urandom_range(0, 1)), 5'(e), 10'($urandom_range(0, 1023))};
        end
    endtask

    task automatic test_reset();
        pulse_reset(2);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 12'h0 || out_exp !== 5'd0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_state in_ready=%b out_valid=%b data=%h exp=%0d last=%b required 1 0 000 0 0",
                     in_ready, out_valid, out_data, out_exp, out_last);
        end
        total++;
        if (in_ready_r !== 1'b1 || out_valid_r !== 1'b0 || out_data_r !== 12'h0 || out_exp_r !== 5'd0 || out_last_r !== 1'b0) begin
            bad++;
            $display("FAIL reset_state_rnd in_ready=%b out_valid=%b data=%h exp=%0d last=%b required 1 0 000 0 0",
                     in_ready_r, out_valid_r, out_data_r, out_exp_r, out_last_r);
        end
    endtask

    task automatic test_basic();
        blk[0] = 16'h4000;
        for (int i = 1; i < BL; i++) blk[i] = 16'h3C00;
        fill_block(BL, 1'b0);
        drain_block(-1, 0, 1'b0);
    endtask

    task automatic test_sign();
        blk[0] = 16'h4000; blk[1] = 16'hBC00; blk[2] = 16'h8000; blk[3] = 16'hC000;
        for (int i = 4; i < BL; i++) blk[i] = {1'($urandom_range(0, 1)), 5'd15, 10'($urandom)};
        fill_block(BL, 1'b1);
        drain_block(-1, 0, 1'b1);
    endtask

    task automatic test_big_shift();
        blk[0] = 16'h7800; blk[1] = 16'h3C00; blk[2] = 16'h4C00; blk[3] = 16'h4800;
        blk[4] = 16'h4FFF; blk[5] = 16'h53FF; blk[6] = 16'h0001; blk[7] = 16'h77FF; blk[8] = 16'hF400;
        fill_block(BL, 1'b0);
        drain_block(-1, 0, 1'b0);
    endtask

    task automatic test_round();
        blk[0] = 16'h4000; blk[1] = 16'h3C01; blk[2] = 16'h3C03; blk[3] = 16'h3BFF;
        blk[4] = 16'h37FF; blk[5] = 16'h3C00; blk[6] = 16'hBC01; blk[7] = 16'h3800; blk[8] = 16'h3C00;
        fill_block(BL, 1'b1);
        drain_block(-1, 0, 1'b0);
    endtask

    task automatic test_zero_block();
        for (int i = 0; i < BL; i++) blk[i] = {1'($urandom_range(0, 1)), 5'd0, 10'($urandom)};
        blk[0] = 16'h0000; blk[1] = 16'h8000;
        fill_block(BL, 1'b0);
        drain_block(-1, 0, 1'b1);
    endtask

    task automatic test_stall();
        gen_random_block();
        fill_block(BL, 1'b0);
        drain_block(3, 6, 1'b0);
        gen_random_block();
        fill_block(BL, 1'b0);
        drain_block(BL - 1, 6, 1'b0);
    endtask

    task automatic test_reset_mid();
        // Partial fill then reset: only the fresh block may appear.
        for (int i = 0; i < BL; i++) blk[i] = 16'h7BFF;
        fill_block(4, 1'b0);
        pulse_reset(1);
        for (int i = 0; i < BL; i++) blk[i] = {1'($urandom_range(0, 1)), 5'($urandom_range(3, 9)), 10'($urandom)};
        fill_block(BL, 1'b0);
        drain_block(-1, 0, 1'b0);
        // Reset part-way through draining.
        for (int i = 0; i < BL; i++) blk[i] = 16'h7800 | 16'(i);
        fill_block(BL, 1'b0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        pulse_reset(1);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 12'h0 || out_exp !== 5'd0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_drain in_ready=%b out_valid=%b data=%h exp=%0d last=%b required 1 0 000 0 0",
                     in_ready, out_valid, out_data, out_exp, out_last);
        end
        gen_random_block();
        fill_block(BL, 1'b1);
        drain_block(-1, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int start;
        gen_random_block();
        start = cyc;
        fill_block(BL, 1'b0);
        drain_block(-1, 0, 1'b0);
        gen_random_block();
        fill_block(BL, 1'b0);
        drain_block(-1, 0, 1'b0);
        total++;
        if (cyc - start > 4 * BL) begin
            bad++;
            $display("FAIL throughput cycles=%0d required<=%0d", cyc - start, 4 * BL);
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 25; b++) begin
            gen_random_block();
            fill_block(BL, b[0]);
            drain_block(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BL - 1)) : -1, 3, 1'b1);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 16'h0;
        test_reset();
        test_basic();
        test_sign();
        test_big_shift();
        test_round();
        test_zero_block();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bfp_stream_normalizer
`default_nettype wire
